// File: rtl/cube_poly_pkg.sv
// Shared constants and FSM state encoding for the cube-engine scheduler
// and anything else that drives the same engine.
package cube_poly_pkg;
  localparam int CUBE_XW     = 2;
  localparam int CUBE_RW     = 3 * CUBE_XW;
  localparam int NREQ_DEF    = 4;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping around. Returns one-hot grant, its index and an any-grant flag.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
)(
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any_grant
);
  logic [IW-1:0] cand;

  always_comb begin
    grant     = '0;
    idx       = '0;
    any_grant = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!any_grant && req[cand]) begin
        any_grant = 1'b1;
        idx       = cand;
      end
    end
    if (any_grant) grant[idx] = 1'b1;
  end
endmodule

// File: rtl/cube_poly_sched.sv
// Round-robin front end for a single sequential cube engine: one op in
// flight, start/finish handshake with timeout, backpressured response.
module cube_poly_sched
  import cube_poly_pkg::*;
#(
  parameter int  NREQ    = NREQ_DEF,
  parameter int  XW      = CUBE_XW,
  parameter int  RW      = CUBE_RW,
  parameter int  TIMEOUT = TIMEOUT_DEF,
  localparam int IW      = $clog2(NREQ)
)(
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*XW-1:0] req_x,
  output logic [NREQ-1:0]    req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IW-1:0]      rsp_id,
  output logic [RW-1:0]      rsp_result,
  output logic               rsp_err,
  output logic               busy,
  output logic               eng_start,
  output logic [XW-1:0]      eng_x,
  input  logic               eng_finish,
  input  logic [RW-1:0]      eng_result
);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] id_q, id_d;
  logic [XW-1:0] x_q, x_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          eng_start_q, eng_start_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [RW-1:0] rsp_result_q, rsp_result_d;
  logic          rsp_err_q, rsp_err_d;

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   gnt_idx;
  logic            any_grant;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .idx       (gnt_idx),
    .any_grant (any_grant)
  );

  // Grant is only offered in IDLE and never while reset is asserted.
  assign req_ready  = (state_q == IDLE && !rst) ? grant : '0;
  assign busy       = (state_q != IDLE);
  assign eng_start  = eng_start_q;
  assign eng_x      = x_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    x_d          = x_q;
    timer_d      = timer_q;
    eng_start_d  = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (any_grant) begin
          x_d         = req_x[gnt_idx*XW +: XW];
          id_d        = gnt_idx;
          eng_start_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A finish on the last allowed cycle still counts as success.
        if (eng_finish) begin
          rsp_result_d = eng_result;
          rsp_err_d    = 1'b0;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          rsp_result_d = '0;
          rsp_err_d    = 1'b1;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = (id_q == IW'(NREQ - 1)) ? '0 : id_q + IW'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      x_q          <= '0;
      timer_q      <= '0;
      eng_start_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      x_q          <= x_d;
      timer_q      <= timer_d;
      eng_start_q  <= eng_start_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
    end
  end
endmodule

// File: tb/tb_cube_poly_sched.sv
// Bench for cube_poly_sched: stub cube engine, round-robin grant model and
// a response scoreboard, driven by a vector table plus corner sequences.
module tb_cube_poly_sched;
  import cube_poly_pkg::*;

  localparam int NREQ = 4, XW = 2, RW = 6, IW = 2, TIMEOUT = 15;

  logic               clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*XW-1:0] req_x = '0;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid, rsp_ready = 1'b1;
  logic [IW-1:0]      rsp_id;
  logic [RW-1:0]      rsp_result;
  logic               rsp_err, busy, eng_start;
  logic [XW-1:0]      eng_x;
  logic               eng_finish;
  logic [RW-1:0]      eng_result;

  cube_poly_sched #(.NREQ(NREQ), .XW(XW), .RW(RW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy),
    .eng_start(eng_start), .eng_x(eng_x), .eng_finish(eng_finish),
    .eng_result(eng_result)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] cube(input logic [XW-1:0] x);
    int v;
    v = int'(x);
    return RW'(v * v * v);
  endfunction

  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return NREQ'(1) << ((p + k) % NREQ);
    return '0;
  endfunction

  // Stub engine: finish drops for two cycles after start; garbage while busy.
  logic          stuck = 1'b0;
  logic [2:0]    e_cnt;
  logic [RW-1:0] e_res;
  always @(posedge clk) begin
    if (rst) begin
      e_cnt <= '0;
      e_res <= '0;
    end else if (eng_start) begin
      e_cnt <= 3'd3;
      e_res <= RW'(eng_x) * RW'(eng_x) * RW'(eng_x);
    end else if (e_cnt != 0) begin
      e_cnt <= e_cnt - 3'd1;
    end
  end
  assign eng_finish = !stuck && (e_cnt <= 3'd1);
  assign eng_result = (e_cnt <= 3'd1) ? e_res : 6'h2A;

  typedef struct {
    int            id;
    logic [XW-1:0] x;
    logic [RW-1:0] res;
    logic          err;
    int            lat;
  } exp_t;

  exp_t          sb[$];
  exp_t          me;
  int            cyc_n = 0, acc_cyc = 0, starts = 0, mptr = 0, g = 0;
  int            n_acc = 0, n_rsp = 0, last_acc_id = 0;
  int            rsp_log[$];
  logic          model_busy = 1'b0, lat_done = 1'b1;
  logic [RW-1:0] last_res = '0;

  always @(posedge clk) cyc_n++;

  // Monitor: samples mid-cycle what the next rising edge will see.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      model_busy = 1'b0;
      mptr       = 0;
      lat_done   = 1'b1;
      check("ready_in_rst", 32'(req_ready), 0);
    end else begin
      check("req_ready", 32'(req_ready), model_busy ? 0 : 32'(rr_pick(req_valid, mptr)));
      if (!model_busy && |(req_valid & req_ready)) begin
        g      = $clog2(req_ready);
        me.id  = g;
        me.x   = req_x[g*XW +: XW];
        me.res = stuck ? '0 : cube(me.x);
        me.err = stuck;
        me.lat = stuck ? TIMEOUT + 2 : 5;
        sb.push_back(me);
        model_busy = 1'b1;
        acc_cyc = cyc_n; starts = 0; lat_done = 1'b0;
        last_acc_id = g;
        n_acc++;
      end
      if (eng_start) begin
        starts++;
        check("start_cycle", 32'(cyc_n - acc_cyc), 1);
        if (sb.size() > 0) check("eng_x", 32'(eng_x), 32'(sb[0].x));
      end
      if (rsp_valid && !lat_done) begin
        lat_done = 1'b1;
        if (sb.size() > 0) check("rsp_latency", 32'(cyc_n - acc_cyc), 32'(sb[0].lat));
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got id %0d, expected no response", rsp_id);
        end else begin
          me = sb.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(me.id));
          check("rsp_result", 32'(rsp_result), 32'(me.res));
          check("rsp_err", 32'(rsp_err), 32'(me.err));
          check("starts_per_op", 32'(starts), 1);
        end
        rsp_log.push_back(int'(rsp_id));
        last_res   = rsp_result;
        n_rsp++;
        model_busy = 1'b0;
        mptr       = (int'(rsp_id) + 1) % NREQ;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Run until n_rsp reaches target; optionally drop each request once granted.
  task automatic wait_rsp(input int target, input int budget, input logic drop);
    int t, seen;
    t = 0;
    seen = n_acc;
    while (n_rsp < target && t < budget) begin
      cyc();
      t++;
      if (drop && n_acc != seen) begin
        seen = n_acc;
        req_valid[last_acc_id] = 1'b0;
      end
    end
    if (n_rsp < target) begin
      checks++; errors++;
      $display("FAIL wait_rsp_timeout: got %0d responses, expected %0d", n_rsp, target);
    end
  endtask

  task automatic check_log(input string name, input int e0, input int e1, input int e2, input int e3);
    int exp_ids[4];
    exp_ids = '{e0, e1, e2, e3};
    check({name, "_len"}, 32'(rsp_log.size()), 4);
    for (int i = 0; i < 4; i++)
      check(name, (i < rsp_log.size()) ? 32'(rsp_log[i]) : 32'hFFFF_FFFF, 32'(exp_ids[i]));
  endtask

  typedef struct { int id; int x; int exp; } vec_t;
  vec_t vt[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t, seen, base;
    vt = '{'{0, 3, 27}, '{2, 2, 8}, '{1, 1, 1}, '{3, 0, 0}, '{3, 3, 27}};

    rst = 1'b1;
    repeat (3) cyc();
    check("rst_outputs", 32'({req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, busy, eng_start, eng_x}), 0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    check("rst_ptr", 32'(dut.rr_ptr_q), 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      req_x = '0;
      req_x[vt[i].id*XW +: XW] = XW'(vt[i].x);
      req_valid = '0;
      req_valid[vt[i].id] = 1'b1;
      wait_rsp(n_rsp + 1, 40, 1'b1);
      check("vec_result", 32'(last_res), 32'(vt[i].exp));
      cyc();
    end

    // All four requesters from reset: served in index order.
    rst = 1'b1; cyc(); rst = 1'b0;
    rsp_log.delete();
    req_x = {2'd3, 2'd2, 2'd1, 2'd0};
    req_valid = 4'hF;
    wait_rsp(n_rsp + 4, 60, 1'b1);
    check_log("order_all4", 0, 1, 2, 3);

    // Two requesters held continuously must alternate.
    rsp_log.delete();
    req_x = {2'd2, 2'd0, 2'd1, 2'd0};
    req_valid = 4'b1010;
    wait_rsp(n_rsp + 4, 60, 1'b0);
    req_valid = '0;
    check_log("alternate", 1, 3, 1, 3);
    cyc(); cyc();

    // Engine never finishes: timeout error, then recovery.
    stuck = 1'b1;
    req_x = 8'h03;
    req_valid = 4'b0001;
    wait_rsp(n_rsp + 1, 40, 1'b1);
    check("timeout_result", 32'(last_res), 0);
    stuck = 1'b0;
    cyc();
    req_x = 8'h20;
    req_valid = 4'b0100;
    wait_rsp(n_rsp + 1, 40, 1'b1);
    check("after_timeout", 32'(last_res), 8);
    cyc();

    // Backpressure: response held stable while req0 waits for its turn.
    base = n_rsp;
    rsp_ready = 1'b0;
    req_x = 8'h08;
    req_valid = 4'b0010;
    seen = n_acc; t = 0;
    while (!rsp_valid && t < 30) begin
      cyc(); t++;
      if (n_acc != seen) begin
        seen = n_acc;
        req_x = 8'h09;
        req_valid = 4'b0001;
      end
    end
    for (int k = 0; k < 4; k++) begin
      check("bp_hold", 32'({rsp_valid, rsp_id, rsp_result, rsp_err}), 32'({1'b1, 2'd1, 6'd8, 1'b0}));
      if (k < 3) cyc();
    end
    rsp_ready = 1'b1;
    wait_rsp(base + 2, 40, 1'b1);
    check("bp_next", 32'(last_res), 1);
    cyc();

    // Reset while in WAIT aborts the op with no response.
    req_x = 8'h03;
    req_valid = 4'b0001;
    seen = n_acc; t = 0;
    while (n_acc == seen && t < 20) begin cyc(); t++; end
    check("abort_accepted", 32'(n_acc - seen), 1);
    req_valid = '0;
    cyc();
    check("abort_in_wait", 32'(dut.state_q), 32'(WAIT));
    rst = 1'b1;
    cyc();
    check("abort_state", 32'(dut.state_q), 32'(IDLE));
    check("abort_ptr", 32'(dut.rr_ptr_q), 0);
    check("abort_outputs", 32'({rsp_valid, rsp_id, rsp_result, rsp_err, busy, eng_start, eng_x}), 0);
    rst = 1'b0;
    base = n_rsp;
    repeat (10) cyc();
    check("abort_no_rsp", 32'(n_rsp), 32'(base));
    req_x = 8'h10;
    req_valid = 4'b0100;
    wait_rsp(base + 1, 40, 1'b1);
    check("after_abort", 32'(last_res), 1);
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cube_poly_sched.md
Name: cube_poly_sched

Overview:
- Round-robin scheduler that shares one sequential cube engine (y = x^3, start/finish handshake, 2-bit x, 6-bit result) among NREQ requesters.
- Accepts one request at a time, pulses the engine start, and waits for finish with a timeout.
- Returns result, requester id and error flag on a shared response channel with backpressure.
- Sits between client blocks and the single cube engine instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- XW, 2, operand width.
- RW, 6, result width; must equal 3*XW.
- TIMEOUT, 15, maximum WAIT cycles before the op is aborted with an error.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  per-requester request.
- req_x  in  NREQ*XW  packed operands; requester i at [i*XW +: XW].
- req_ready  out  NREQ  one-hot grant; accept happens when req_valid[i] & req_ready[i].
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  $clog2(NREQ)  requester index of the response.
- rsp_result  out  RW  x^3, or 0 on error.
- rsp_err  out  1  engine timeout.
- busy  out  1  high in any state other than IDLE.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_x  out  XW  operand to the engine; valid while eng_start=1.
- eng_finish  in  1  engine idle/done (high when not computing).
- eng_result  in  RW  engine result; valid when eng_finish=1 after a start.

Behaviour:
- Reset values:
  - state=IDLE, rr_ptr=0.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0.
  - eng_start=0, eng_x=0, busy=0, timer=0.
  - The engine's reset is driven from rst at integration.
- IDLE:
  - The rr_arbiter picks the first asserted req_valid at or after rr_ptr, cyclically.
  - req_ready[grant] is asserted combinationally in the same cycle; the other bits stay 0.
  - On that edge: latch x and id, go to ISSUE.
  - If no req_valid: stay in IDLE, req_ready=0.
- ISSUE (1 cycle): eng_start=1, eng_x=latched x, timer cleared; go to WAIT.
- WAIT:
  - eng_finish=1 → capture eng_result, err=0, go to RESP.
  - Otherwise timer+1.
  - timer==TIMEOUT-1 with eng_finish still 0 → result=0, err=1, go to RESP.
  - Finish and timeout in the same cycle → finish wins.
- RESP:
  - rsp_valid=1; rsp_id, rsp_result and rsp_err are held stable until rsp_ready.
  - On rsp_valid & rsp_ready: rr_ptr = (id+1) mod NREQ, go to IDLE.
- Latency with a nominal engine:
  - Accept edge E0; ISSUE in cycle 1.
  - eng_finish is low in cycles 2–3 and high in cycle 4.
  - rsp_valid first high in cycle 5.
  - Minimum spacing between accepts is 6 cycles with rsp_ready held at 1.
- One outstanding op only: req_ready=0 in ISSUE, WAIT and RESP.
- req_valid is not required to be sticky; a dropped request is simply not granted.
- rr_ptr advances only on response completion, so the last-served requester becomes lowest priority.
- rst high in any state forces the reset values on the next edge:
  - An in-flight op is discarded with no response.
  - eng_start is 0 during reset.
- eng_result is never sampled outside WAIT.
- Width rule: no truncation; (2^XW-1)^3 fits in RW=3*XW.

Decomposition:
- Package cube_poly_pkg:
  - XW and RW constants.
  - state_t enum {IDLE, ISSUE, WAIT, RESP}.
  - Default NREQ and TIMEOUT.
- Sub-module rr_arbiter:
  - Purely combinational.
  - Inputs: req vector, rr_ptr. Outputs: one-hot grant, grant index, any_grant.
  - Reusable by other shared-engine schedulers.

Test Plan:
- Single request, req0 x=3, rsp_ready=1 → req_ready[0] at cycle 0, one eng_start pulse with eng_x=3, rsp_valid at cycle 5 with id=0, result=27, err=0.
- req0..3 all valid with x=0,1,2,3 from reset, rsp_ready=1 → responses in id order 0,1,2,3 with results 0,1,8,27; exactly one eng_start per op.
- req1 and req3 held valid continuously → grants alternate 1,3,1,3…; neither is granted twice in a row.
- Stub engine with eng_finish stuck at 0 → after ISSUE, 15 WAIT cycles then RESP with err=1, result=0; next request still serviced after the stub is released.
- x=2 with rsp_ready low for 3 cycles in RESP → rsp_valid/id/result=8 stable for all 4 cycles, no new req_ready until after the handshake.
- rst asserted for 1 cycle while in WAIT → next cycle state IDLE, all outputs at reset values, rr_ptr=0, no response for the aborted op; a following req2 x=1 returns 1.
